// File: rtl/cm0_dbg_bkpt_track.sv
// Breakpoint match tracker: carries per-halfword comparator match flags
// through the prefetch buffer alongside the fetched words, and raises a
// sticky halt request when a flagged halfword reaches decode.
module cm0_dbg_bkpt_track #(
  parameter int DBG  = 1,
  parameter int BKPT = 4,
  parameter int PFW  = 2
) (
  input  logic       dclk,
  input  logic       dbg_reset_n,
  input  logic [1:0] bpu_match_i,
  input  logic       fetch_data_i,
  input  logic       fetch_skip_lo_i,
  input  logic [1:0] dec_pop_i,
  input  logic       dec_valid_i,
  input  logic       flush_i,
  input  logic       dbg_c_debugen_i,
  input  logic       dbg_halted_i,
  input  logic       hreq_ack_i,
  output logic       head_match_o,
  output logic       hreq_o,
  output logic       bkpt_evt_o,
  output logic [2:0] fill_o
);

  localparam int CAP = 2 * PFW;
  localparam int PW  = (CAP > 2) ? $clog2(CAP) : 1;

  generate
    if (DBG != 0 && BKPT != 0) begin : g_track

      typedef enum logic {
        IDLE,
        REQ
      } state_t;

      state_t         state_q, state_d;
      logic [CAP-1:0] flags_q, flags_d;
      logic [PW-1:0]  rd_q, rd_d;
      logic [PW-1:0]  wr_q, wr_d;
      logic [3:0]     count_q, count_d;
      logic           evt_q, evt_d;
      logic [3:0]     pop_req;
      logic [3:0]     pop_n;
      logic [3:0]     push_n;
      logic           push_ok;
      logic           flush_all;
      logic           halt_go;
      logic           head_match;

      // Advance a circular pointer by n, wrapping at CAP even when CAP is not a power of two.
      function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input logic [3:0] n);
        logic [4:0] s;
        s = {{(5-PW){1'b0}}, ptr} + {1'b0, n};
        if (s >= 5'(CAP)) s = s - 5'(CAP);
        return s[PW-1:0];
      endfunction

      assign flush_all  = flush_i | hreq_ack_i;
      assign head_match = (count_q != 4'd0) & flags_q[rd_q];

      // Flag store update: pop is clamped against the pre-push occupancy; a push is dropped
      // whole if the net occupancy after this cycle's pop would exceed capacity.
      always_comb begin
        flags_d = flags_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        pop_req = (dec_pop_i == 2'd3) ? 4'd0 : {2'b00, dec_pop_i};
        pop_n   = (pop_req > count_q) ? count_q : pop_req;
        if (!fetch_data_i)        push_n = 4'd0;
        else if (fetch_skip_lo_i) push_n = 4'd1;
        else                      push_n = 4'd2;
        push_ok = ((count_q - pop_n) + push_n) <= 4'(CAP);
        if (flush_all) begin
          rd_d    = '0;
          wr_d    = '0;
          count_d = 4'd0;
        end else begin
          rd_d    = wrap_add(rd_q, pop_n);
          count_d = count_q - pop_n;
          if (push_ok && push_n != 4'd0) begin
            if (fetch_skip_lo_i) begin
              flags_d[wr_q] = bpu_match_i[1];
            end else begin
              flags_d[wr_q]                 = bpu_match_i[0];
              flags_d[wrap_add(wr_q, 4'd1)] = bpu_match_i[1];
            end
            wr_d    = wrap_add(wr_q, push_n);
            count_d = count_d + push_n;
          end
        end
      end

      // Halt request FSM: a flagged head presented to decode raises a request held until acked.
      always_comb begin
        state_d = state_q;
        evt_d   = 1'b0;
        halt_go = dec_valid_i & head_match & dbg_c_debugen_i & ~dbg_halted_i & ~flush_i;
        case (state_q)
          IDLE: begin
            if (halt_go) begin
              state_d = REQ;
              evt_d   = 1'b1;
            end
          end
          REQ: begin
            if (hreq_ack_i) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end

      // State registers with synchronous active-low reset.
      always_ff @(posedge dclk) begin
        if (!dbg_reset_n) begin
          state_q <= IDLE;
          flags_q <= '0;
          rd_q    <= '0;
          wr_q    <= '0;
          count_q <= 4'd0;
          evt_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          flags_q <= flags_d;
          rd_q    <= rd_d;
          wr_q    <= wr_d;
          count_q <= count_d;
          evt_q   <= evt_d;
        end
      end

      assign head_match_o = head_match;
      assign hreq_o       = (state_q == REQ);
      assign bkpt_evt_o   = evt_q;
      assign fill_o       = (count_q > 4'd7) ? 3'd7 : count_q[2:0];

      ap_push_ovf: assert property (@(posedge dclk) disable iff (!dbg_reset_n)
        !(fetch_data_i && !flush_all && !push_ok))
        else $warning("bkpt_track: push dropped, flag buffer full");

      ap_pop_under: assert property (@(posedge dclk) disable iff (!dbg_reset_n)
        !(pop_req > count_q))
        else $warning("bkpt_track: pop larger than occupancy, clamped");

      ap_pop_three: assert property (@(posedge dclk) disable iff (!dbg_reset_n)
        dec_pop_i != 2'd3)
        else $warning("bkpt_track: dec_pop_i of 3 treated as 0");

      ap_pop_in_req: assert property (@(posedge dclk) disable iff (!dbg_reset_n)
        !(state_q == REQ && dec_pop_i != 2'd0))
        else $warning("bkpt_track: decode consumed while halt requested");

    end else begin : g_absent
      assign head_match_o = 1'b0;
      assign hreq_o       = 1'b0;
      assign bkpt_evt_o   = 1'b0;
      assign fill_o       = 3'd0;
    end
  endgenerate

endmodule

// File: tb/tb_cm0_dbg_bkpt_track.sv
// Testbench for cm0_dbg_bkpt_track: directed vector table, a wrap sequence,
// and randomized traffic against a queue-based reference model.
module tb_cm0_dbg_bkpt_track;

  localparam int CAP = 4;

  logic       dclk = 1'b0;
  logic       dbg_reset_n;
  logic [1:0] bpu_match_i;
  logic       fetch_data_i;
  logic       fetch_skip_lo_i;
  logic [1:0] dec_pop_i;
  logic       dec_valid_i;
  logic       flush_i;
  logic       dbg_c_debugen_i;
  logic       dbg_halted_i;
  logic       hreq_ack_i;
  logic       head_match_o;
  logic       hreq_o;
  logic       bkpt_evt_o;
  logic [2:0] fill_o;

  int checks   = 0;
  int failures = 0;

  bit mq[$];
  bit m_req = 1'b0;
  bit m_evt = 1'b0;

  typedef struct {
    logic       rst_n;
    logic       fetch;
    logic       skip;
    logic [1:0] match;
    logic [1:0] pop;
    logic       valid;
    logic       flush;
    logic       en;
    logic       halted;
    logic       ack;
    logic [2:0] e_fill;
    logic       e_head;
    logic       e_hreq;
    logic       e_evt;
  } vec_t;

  vec_t tbl[$];

  cm0_dbg_bkpt_track #(.DBG(1), .BKPT(4), .PFW(2)) dut (
    .dclk            (dclk),
    .dbg_reset_n     (dbg_reset_n),
    .bpu_match_i     (bpu_match_i),
    .fetch_data_i    (fetch_data_i),
    .fetch_skip_lo_i (fetch_skip_lo_i),
    .dec_pop_i       (dec_pop_i),
    .dec_valid_i     (dec_valid_i),
    .flush_i         (flush_i),
    .dbg_c_debugen_i (dbg_c_debugen_i),
    .dbg_halted_i    (dbg_halted_i),
    .hreq_ack_i      (hreq_ack_i),
    .head_match_o    (head_match_o),
    .hreq_o          (hreq_o),
    .bkpt_evt_o      (bkpt_evt_o),
    .fill_o          (fill_o)
  );

  // Free-running debug clock.
  always #5 dclk = ~dclk;

  // Reference model: flags are a FIFO of halfwords, the request a sticky bit.
  task automatic modelStep();
    int  n_pop;
    bit  head;
    bit  go;
    if (!dbg_reset_n) begin
      mq.delete();
      m_req = 1'b0;
      m_evt = 1'b0;
      return;
    end
    head  = (mq.size() > 0) ? mq[0] : 1'b0;
    go    = !m_req && dec_valid_i && head && dbg_c_debugen_i && !dbg_halted_i && !flush_i;
    n_pop = (dec_pop_i == 2'd3) ? 0 : int'(dec_pop_i);
    if (n_pop > mq.size()) n_pop = mq.size();
    if (flush_i || hreq_ack_i) begin
      mq.delete();
    end else begin
      repeat (n_pop) mq.delete(0);
      if (fetch_data_i) begin
        if (fetch_skip_lo_i) begin
          if (mq.size() + 1 <= CAP) mq.push_back(bpu_match_i[1]);
        end else if (mq.size() + 2 <= CAP) begin
          mq.push_back(bpu_match_i[0]);
          mq.push_back(bpu_match_i[1]);
        end
      end
    end
    m_evt = go;
    if (m_req && hreq_ack_i) m_req = 1'b0;
    else if (go)             m_req = 1'b1;
  endtask

  task automatic drive(input logic rst_n, input logic fetch, input logic skip, input logic [1:0] match,
                       input logic [1:0] pop, input logic valid, input logic flush, input logic en,
                       input logic halted, input logic ack);
    dbg_reset_n     = rst_n;
    fetch_data_i    = fetch;
    fetch_skip_lo_i = skip;
    bpu_match_i     = match;
    dec_pop_i       = pop;
    dec_valid_i     = valid;
    flush_i         = flush;
    dbg_c_debugen_i = en;
    dbg_halted_i    = halted;
    hreq_ack_i      = ack;
    modelStep();
    @(posedge dclk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.rst_n, v.fetch, v.skip, v.match, v.pop, v.valid, v.flush, v.en, v.halted, v.ack);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] e_fill, input logic e_head,
                             input logic e_hreq, input logic e_evt);
    checks++;
    if (fill_o !== e_fill) begin
      failures++;
      $display("[TB] FAIL %s fill_o: got %0d want %0d", name, fill_o, e_fill);
    end
    checks++;
    if (head_match_o !== e_head) begin
      failures++;
      $display("[TB] FAIL %s head_match_o: got %b want %b", name, head_match_o, e_head);
    end
    checks++;
    if (hreq_o !== e_hreq) begin
      failures++;
      $display("[TB] FAIL %s hreq_o: got %b want %b", name, hreq_o, e_hreq);
    end
    checks++;
    if (bkpt_evt_o !== e_evt) begin
      failures++;
      $display("[TB] FAIL %s bkpt_evt_o: got %b want %b", name, bkpt_evt_o, e_evt);
    end
  endtask

  task automatic addVec(input logic rst_n, input logic fetch, input logic skip, input logic [1:0] match,
                        input logic [1:0] pop, input logic valid, input logic flush, input logic en,
                        input logic halted, input logic ack, input logic [2:0] e_fill,
                        input logic e_head, input logic e_hreq, input logic e_evt);
    vec_t v;
    v.rst_n = rst_n; v.fetch = fetch; v.skip = skip; v.match = match; v.pop = pop;
    v.valid = valid; v.flush = flush; v.en = en; v.halted = halted; v.ack = ack;
    v.e_fill = e_fill; v.e_head = e_head; v.e_hreq = e_hreq; v.e_evt = e_evt;
    tbl.push_back(v);
  endtask

  // Main test sequence.
  initial begin
    // rst fetch skip match pop valid flush en halted ack | fill head hreq evt
    addVec(0, 1, 0, 2'b11, 2'd2, 1, 0, 1, 0, 0,  3'd0, 0, 0, 0);  // reset with garbage inputs
    addVec(1, 1, 0, 2'b11, 2'd0, 0, 0, 1, 0, 0,  3'd2, 1, 0, 0);
    addVec(0, 1, 0, 2'b11, 2'd0, 1, 0, 1, 0, 0,  3'd0, 0, 0, 0);  // reset mid-operation
    addVec(1, 1, 0, 2'b10, 2'd0, 0, 0, 1, 0, 0,  3'd2, 0, 0, 0);  // upper-hw hit
    addVec(1, 0, 0, 2'b00, 2'd1, 0, 0, 1, 0, 0,  3'd1, 1, 0, 0);
    addVec(1, 0, 0, 2'b00, 2'd0, 1, 0, 1, 0, 0,  3'd1, 1, 1, 1);
    for (int i = 0; i < 4; i++)
      addVec(1, 0, 0, 2'b00, 2'd0, 1, 0, 1, 0, 0, 3'd1, 1, 1, 0);
    addVec(1, 0, 0, 2'b00, 2'd0, 0, 0, 1, 0, 1,  3'd0, 0, 0, 0);  // ack
    addVec(1, 0, 0, 2'b00, 2'd0, 0, 1, 1, 0, 0,  3'd0, 0, 0, 0);  // skip_lo
    addVec(1, 1, 1, 2'b11, 2'd0, 0, 0, 1, 0, 0,  3'd1, 1, 0, 0);
    addVec(1, 0, 0, 2'b00, 2'd1, 0, 0, 1, 0, 0,  3'd0, 0, 0, 0);
    addVec(1, 1, 0, 2'b00, 2'd0, 0, 0, 1, 0, 0,  3'd2, 0, 0, 0);  // collisions
    addVec(1, 1, 0, 2'b00, 2'd2, 0, 0, 1, 0, 0,  3'd2, 0, 0, 0);
    addVec(1, 1, 0, 2'b11, 2'd0, 0, 1, 1, 0, 0,  3'd0, 0, 0, 0);
    addVec(1, 1, 1, 2'b00, 2'd0, 0, 0, 1, 0, 0,  3'd1, 0, 0, 0);
    addVec(1, 1, 0, 2'b00, 2'd0, 0, 0, 1, 0, 0,  3'd3, 0, 0, 0);
    addVec(1, 1, 0, 2'b11, 2'd0, 0, 0, 1, 0, 0,  3'd3, 0, 0, 0);  // overflow dropped
    addVec(1, 0, 0, 2'b00, 2'd2, 0, 0, 1, 0, 0,  3'd1, 0, 0, 0);
    addVec(1, 0, 0, 2'b00, 2'd2, 0, 0, 1, 0, 0,  3'd0, 0, 0, 0);  // pop clamped
    addVec(1, 1, 0, 2'b00, 2'd0, 0, 0, 1, 0, 0,  3'd2, 0, 0, 0);
    addVec(1, 0, 0, 2'b00, 2'd3, 0, 0, 1, 0, 0,  3'd2, 0, 0, 0);  // pop of 3 ignored
    addVec(1, 0, 0, 2'b00, 2'd0, 0, 1, 1, 0, 0,  3'd0, 0, 0, 0);
    addVec(1, 1, 0, 2'b01, 2'd0, 0, 0, 1, 0, 0,  3'd2, 1, 0, 0);  // gating
    addVec(1, 0, 0, 2'b00, 2'd0, 1, 0, 1, 1, 0,  3'd2, 1, 0, 0);
    addVec(1, 0, 0, 2'b00, 2'd0, 1, 0, 0, 0, 0,  3'd2, 1, 0, 0);
    addVec(1, 0, 0, 2'b00, 2'd0, 1, 1, 1, 0, 0,  3'd0, 0, 0, 0);
    addVec(1, 1, 0, 2'b01, 2'd0, 0, 0, 1, 0, 0,  3'd2, 1, 0, 0);
    addVec(1, 0, 0, 2'b00, 2'd0, 1, 0, 0, 0, 0,  3'd2, 1, 0, 0);
    addVec(1, 0, 0, 2'b00, 2'd0, 1, 0, 1, 0, 0,  3'd2, 1, 1, 1);  // debugen raised
    addVec(1, 0, 0, 2'b00, 2'd0, 0, 1, 1, 0, 0,  3'd0, 0, 1, 0);  // flush keeps request
    addVec(1, 0, 0, 2'b00, 2'd0, 0, 0, 1, 0, 1,  3'd0, 0, 0, 0);
    addVec(1, 1, 0, 2'b11, 2'd0, 0, 0, 1, 0, 1,  3'd0, 0, 0, 0);  // idle ack flushes

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vec%0d", i), tbl[i].e_fill, tbl[i].e_head, tbl[i].e_hreq, tbl[i].e_evt);
    end

    // Wrap: pointers cycle the 4-entry store with a 1-hw skew; only the 4th word's lower hw is flagged.
    drive(0, 0, 0, 2'b00, 2'd0, 0, 0, 1, 0, 0);
    drive(1, 1, 0, 2'b00, 2'd0, 0, 0, 1, 0, 0);
    checkOutput("wrap_w1", 3'd2, 0, 0, 0);
    drive(1, 0, 0, 2'b00, 2'd1, 0, 0, 1, 0, 0);
    checkOutput("wrap_skew", 3'd1, 0, 0, 0);
    drive(1, 1, 0, 2'b00, 2'd1, 0, 0, 1, 0, 0);
    checkOutput("wrap_w2", 3'd2, 0, 0, 0);
    for (int k = 3; k <= 6; k++) begin
      drive(1, 1, 0, (k == 4) ? 2'b01 : 2'b00, 2'd2, 0, 0, 1, 0, 0);
      checkOutput($sformatf("wrap_w%0d", k), 3'd2, (k == 4), 0, 0);
    end

    // Randomized traffic against the reference model.
    drive(0, 0, 0, 2'b00, 2'd0, 0, 0, 1, 0, 0);
    for (int n = 0; n < 800; n++) begin
      logic       r_rst, r_fetch, r_skip, r_valid, r_flush, r_en, r_halt, r_ack;
      logic [1:0] r_match, r_pop;
      int         lim;
      r_rst   = ($urandom % 100) != 0;
      r_fetch = $urandom % 2;
      r_skip  = ($urandom % 4) == 0;
      r_match = (($urandom % 3) == 0) ? 2'($urandom) : 2'b00;
      lim     = (mq.size() < 2) ? mq.size() : 2;
      r_pop   = 2'($urandom_range(0, lim));
      if (($urandom % 25) == 0) r_pop = 2'($urandom);
      if (m_req) r_pop = 2'd0;
      r_valid = $urandom % 2;
      r_flush = ($urandom % 16) == 0;
      r_en    = ($urandom % 8) != 0;
      r_halt  = ($urandom % 8) == 0;
      r_ack   = m_req ? (($urandom % 4) == 0) : (($urandom % 30) == 0);
      drive(r_rst, r_fetch, r_skip, r_match, r_pop, r_valid, r_flush, r_en, r_halt, r_ack);
      checkOutput($sformatf("rand%0d", n), 3'(mq.size()), (mq.size() > 0) ? mq[0] : 1'b0, m_req, m_evt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
